// File: rtl/instruction_fetch_unit.sv
// Program store and in-order word sequencer feeding the instruction decoder.
// Optional FETCH_LOOP_EN adds loop_count: the program repeats loop_count+1 times per start.
module instruction_fetch_unit #(
    parameter int unsigned INSTR_WIDTH = 88,
    parameter int unsigned DEPTH       = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       host_wr_valid,
    output logic                       host_wr_ready,
    input  logic [INSTR_WIDTH-1:0]     host_wr_data,
    input  logic                       host_clear,
    input  logic                       start,
    input  logic                       stall,
    input  logic                       abort,
`ifdef FETCH_LOOP_EN
    input  logic [7:0]                 loop_count,
`endif
    output logic [INSTR_WIDTH-1:0]     instruction,
    output logic                       instr_valid,
    output logic [$clog2(DEPTH)-1:0]   pc,
    output logic [$clog2(DEPTH):0]     prog_len,
    output logic                       busy,
    output logic                       done
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = AW + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t                   state, state_nxt;
    logic [INSTR_WIDTH-1:0]   mem [DEPTH];
    logic [INSTR_WIDTH-1:0]   instr_nxt;
    logic                     valid_nxt;
    logic [AW-1:0]            pc_nxt;
    logic [LW-1:0]            len_nxt;
    logic                     mem_we;
    logic                     last_word;
`ifdef FETCH_LOOP_EN
    logic [7:0]               loop_cnt, loop_nxt;
`endif

    assign last_word = (LW'(pc) + LW'(1)) == prog_len;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state, issue datapath and host-load decode
    always_comb begin
        state_nxt = state;
        instr_nxt = '0;
        valid_nxt = 1'b0;
        pc_nxt    = pc;
        len_nxt   = prog_len;
        mem_we    = 1'b0;
`ifdef FETCH_LOOP_EN
        loop_nxt  = loop_cnt;
`endif

        if (abort) begin
            state_nxt = IDLE;
            pc_nxt    = '0;
`ifdef FETCH_LOOP_EN
            loop_nxt  = 8'd0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        pc_nxt = '0;
                        if (prog_len != '0) begin
                            state_nxt = RUN;
`ifdef FETCH_LOOP_EN
                            loop_nxt  = loop_count;
`endif
                        end else begin
                            state_nxt = DONE;
                        end
                    end
                end
                RUN: begin
                    if (!stall) begin
                        instr_nxt = mem[pc];
                        valid_nxt = 1'b1;
                        pc_nxt    = pc + AW'(1);
                        if (last_word) begin
`ifdef FETCH_LOOP_EN
                            if (loop_cnt != 8'd0) begin
                                loop_nxt = loop_cnt - 8'd1;
                                pc_nxt   = '0;
                            end else begin
                                state_nxt = DONE;
                            end
`else
                            state_nxt = DONE;
`endif
                        end
                    end
                end
                DONE: begin
                    state_nxt = IDLE;
                    pc_nxt    = '0;
                end
                default: begin
                    state_nxt = IDLE;
                    pc_nxt    = '0;
                end
            endcase
        end

        // Host loading is only honoured while idle; clear beats a same-cycle write
        if (state == IDLE) begin
            if (host_clear) begin
                len_nxt = '0;
            end else if (host_wr_valid && (prog_len < LW'(DEPTH))) begin
                mem_we  = 1'b1;
                len_nxt = prog_len + LW'(1);
            end
        end
    end

    // Registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instruction   <= '0;
            instr_valid   <= 1'b0;
            pc            <= '0;
            prog_len      <= '0;
            busy          <= 1'b0;
            done          <= 1'b0;
            host_wr_ready <= 1'b1;
        end else begin
            instruction   <= instr_nxt;
            instr_valid   <= valid_nxt;
            pc            <= pc_nxt;
            prog_len      <= len_nxt;
            busy          <= (state_nxt != IDLE);
            done          <= (state_nxt == DONE);
            host_wr_ready <= (state_nxt == IDLE) && (len_nxt < LW'(DEPTH));
        end
    end

`ifdef FETCH_LOOP_EN
    // Remaining extra passes
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            loop_cnt <= 8'd0;
        end else begin
            loop_cnt <= loop_nxt;
        end
    end
`endif

    // Program store, intentionally not reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[prog_len[AW-1:0]] <= host_wr_data;
        end
    end

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed self-checking bench for instruction_fetch_unit.
module tb_instruction_fetch_unit;

    localparam int unsigned W  = 88;
    localparam int unsigned DP = 64;
    localparam int unsigned AW = $clog2(DP);

    logic           clk = 1'b0;
    logic           rst_n;
    logic           host_wr_valid;
    logic           host_wr_ready;
    logic [W-1:0]   host_wr_data;
    logic           host_clear;
    logic           start;
    logic           stall;
    logic           abort;
`ifdef FETCH_LOOP_EN
    logic [7:0]     loop_count;
`endif
    logic [W-1:0]   instruction;
    logic           instr_valid;
    logic [AW-1:0]  pc;
    logic [AW:0]    prog_len;
    logic           busy;
    logic           done;

    int errors = 0;
    int checks = 0;

    localparam logic [W-1:0] WA = 88'hAAAA_0000_1111_2222_3333_44;
    localparam logic [W-1:0] WB = 88'hBBBB_5555_6666_7777_8888_99;
    localparam logic [W-1:0] WC = 88'hCCCC_DEAD_BEEF_0123_4567_89;
    localparam logic [W-1:0] WD = 88'hDDDD_0F0F_F0F0_1234_5678_9A;

    instruction_fetch_unit #(.INSTR_WIDTH(W), .DEPTH(DP)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .host_wr_valid (host_wr_valid),
        .host_wr_ready (host_wr_ready),
        .host_wr_data  (host_wr_data),
        .host_clear    (host_clear),
        .start         (start),
        .stall         (stall),
        .abort         (abort),
`ifdef FETCH_LOOP_EN
        .loop_count    (loop_count),
`endif
        .instruction   (instruction),
        .instr_valid   (instr_valid),
        .pc            (pc),
        .prog_len      (prog_len),
        .busy          (busy),
        .done          (done)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [W-1:0] w);
        host_wr_valid = 1'b1;
        host_wr_data  = w;
        tick();
        host_wr_valid = 1'b0;
    endtask

    task automatic clear_prog();
        host_clear = 1'b1;
        tick();
        host_clear = 1'b0;
    endtask

    task automatic issue(input string tag, input logic [W-1:0] w, input logic v,
                         input logic [AW-1:0] p, input logic d);
        tick();
        chk({tag, ".instr"}, 128'(instruction), 128'(w));
        chk({tag, ".valid"}, 128'(instr_valid), 128'(v));
        chk({tag, ".pc"},    128'(pc),          128'(p));
        chk({tag, ".done"},  128'(done),        128'(d));
    endtask

    function automatic logic [W-1:0] pat(input int i);
        return {8'(i), 16'hC0DE, 64'(i * 3 + 7)};
    endfunction

    initial begin
        rst_n = 1'b0; host_wr_valid = 1'b0; host_wr_data = '0; host_clear = 1'b0;
        start = 1'b0; stall = 1'b0; abort = 1'b0;
`ifdef FETCH_LOOP_EN
        loop_count = 8'd0;
`endif
        tick(); tick();
        chk("rst.instr", 128'(instruction), 128'(0));
        chk("rst.valid", 128'(instr_valid), 128'(0));
        chk("rst.pc",    128'(pc),          128'(0));
        chk("rst.len",   128'(prog_len),    128'(0));
        chk("rst.busy",  128'(busy),        128'(0));
        chk("rst.done",  128'(done),        128'(0));
        chk("rst.ready", 128'(host_wr_ready), 128'(1));
        rst_n = 1'b1;
        tick();

        // Three words straight through
        load(WA); load(WB); load(WC);
        chk("t1.len", 128'(prog_len), 128'(3));
        start = 1'b1; tick(); start = 1'b0;
        chk("t1.busy",  128'(busy),  128'(1));
        chk("t1.ready", 128'(host_wr_ready), 128'(0));
        chk("t1.v0",    128'(instr_valid), 128'(0));
        issue("t1.a", WA, 1'b1, 6'd1, 1'b0);
        issue("t1.b", WB, 1'b1, 6'd2, 1'b0);
        tick();
        chk("t1.c.instr", 128'(instruction), 128'(WC));
        chk("t1.c.done",  128'(done), 128'(1));
        issue("t1.end", '0, 1'b0, 6'd0, 1'b0);
        chk("t1.end.busy", 128'(busy), 128'(0));

        // Two stall cycles after the first word
        start = 1'b1; tick(); start = 1'b0;
        issue("t2.a", WA, 1'b1, 6'd1, 1'b0);
        stall = 1'b1;
        issue("t2.s1", '0, 1'b0, 6'd1, 1'b0);
        issue("t2.s2", '0, 1'b0, 6'd1, 1'b0);
        stall = 1'b0;
        issue("t2.b", WB, 1'b1, 6'd2, 1'b0);
        tick();
        chk("t2.c.instr", 128'(instruction), 128'(WC));
        chk("t2.c.done",  128'(done), 128'(1));
        issue("t2.end", '0, 1'b0, 6'd0, 1'b0);

        // Abort on the second of four words, then restart from word 0
        clear_prog();
        load(WA); load(WB); load(WC); load(WD);
        chk("t5.len", 128'(prog_len), 128'(4));
        start = 1'b1; tick(); start = 1'b0;
        issue("t5.a", WA, 1'b1, 6'd1, 1'b0);
        issue("t5.b", WB, 1'b1, 6'd2, 1'b0);
        abort = 1'b1;
        issue("t5.abort", '0, 1'b0, 6'd0, 1'b0);
        abort = 1'b0;
        chk("t5.busy", 128'(busy), 128'(0));
        chk("t5.len2", 128'(prog_len), 128'(4));
        tick();
        chk("t5.nodone", 128'(done), 128'(0));
        start = 1'b1; tick(); start = 1'b0;
        issue("t5.ra", WA, 1'b1, 6'd1, 1'b0);
        issue("t5.rb", WB, 1'b1, 6'd2, 1'b0);
        issue("t5.rc", WC, 1'b1, 6'd3, 1'b0);
        tick();
        chk("t5.rd.instr", 128'(instruction), 128'(WD));
        chk("t5.rd.done",  128'(done), 128'(1));
        tick();

        // Empty program: immediate done, nothing issued
        clear_prog();
        chk("t4.len", 128'(prog_len), 128'(0));
        start = 1'b1; tick(); start = 1'b0;
        chk("t4.done",  128'(done), 128'(1));
        chk("t4.busy",  128'(busy), 128'(1));
        chk("t4.valid", 128'(instr_valid), 128'(0));
        issue("t4.end", '0, 1'b0, 6'd0, 1'b0);
        chk("t4.busy2", 128'(busy), 128'(0));

        // Fill to DEPTH, overflow write dropped, full program replays
        for (int i = 0; i < 63; i++) load(pat(i));
        chk("t3.ready63", 128'(host_wr_ready), 128'(1));
        load(pat(63));
        chk("t3.len64",   128'(prog_len), 128'(64));
        chk("t3.ready64", 128'(host_wr_ready), 128'(0));
        load(88'hFFFF_FFFF_FFFF_FFFF_FFFF_FF);
        chk("t3.len65",   128'(prog_len), 128'(64));
        start = 1'b1; tick(); start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            tick();
            chk("t3.word", 128'(instruction), 128'(pat(i)));
            chk("t3.done", 128'(done), 128'(i == 63));
        end
        issue("t3.end", '0, 1'b0, 6'd0, 1'b0);

`ifdef FETCH_LOOP_EN
        // Two passes over a two-word program, single done at the end
        clear_prog();
        load(WA); load(WB);
        loop_count = 8'd1;
        start = 1'b1; tick(); start = 1'b0; loop_count = 8'd0;
        issue("t6.a0", WA, 1'b1, 6'd1, 1'b0);
        issue("t6.b0", WB, 1'b1, 6'd0, 1'b0);
        issue("t6.a1", WA, 1'b1, 6'd1, 1'b0);
        tick();
        chk("t6.b1.instr", 128'(instruction), 128'(WB));
        chk("t6.b1.done",  128'(done), 128'(1));
        issue("t6.end", '0, 1'b0, 6'd0, 1'b0);
`endif

        // Asynchronous reset in the middle of a run
        clear_prog();
        load(WA); load(WB);
        start = 1'b1; tick(); start = 1'b0;
        issue("t7.a", WA, 1'b1, 6'd1, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t7.instr", 128'(instruction), 128'(0));
        chk("t7.valid", 128'(instr_valid), 128'(0));
        chk("t7.pc",    128'(pc),          128'(0));
        chk("t7.len",   128'(prog_len),    128'(0));
        chk("t7.busy",  128'(busy),        128'(0));
        chk("t7.done",  128'(done),        128'(0));
        tick();
        rst_n = 1'b1;
        tick();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
